// File: rtl/reg_dump_pkg.sv
// Shared constants and state encoding for the register-file dump engine.
package reg_dump_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2**ADDR_WIDTH;
  localparam int CSUM_ADDR  = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_CSUM,
    S_DRAIN
  } state_e;
endpackage

// File: rtl/reg_dump_obuf.sv
// Single output register stage with valid/ready hold; loads whenever empty or being drained.
module reg_dump_obuf
  import reg_dump_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_req,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic          in_csum,
  output logic          load_en,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_csum
);
  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;
  logic          csum_q, csum_d;

  assign load_en = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    csum_d  = csum_q;
    // A free slot either takes a new beat or goes empty; a stalled beat is untouched.
    if (load_en) begin
      valid_d = load_req;
      if (load_req) begin
        addr_d = in_addr;
        data_d = in_data;
        last_d = in_last;
        csum_d = in_csum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      csum_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      csum_q  <= csum_d;
    end
  end

  assign out_valid = valid_q;
  assign out_addr  = addr_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_csum  = csum_q;
endmodule

// File: rtl/reg_dump.sv
// Register-file dump engine: walks lo..hi (with wrap) and streams {addr,data} beats.
// Define REG_DUMP_CSUM_EN to append a trailing checksum beat.
module reg_dump #(
  parameter int DATA_WIDTH = reg_dump_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_dump_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] lo_addr,
  input  logic [ADDR_WIDTH-1:0] hi_addr,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_csum,
  output logic                  busy,
  output logic                  done
);
  import reg_dump_pkg::*;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_q, cur_d;
  logic [ADDR_WIDTH-1:0]   hi_q, hi_d;
  logic                    done_q, done_d;
  logic                    load_req, load_en, beat_last, beat_csum;
  logic [ADDR_WIDTH-1:0]   beat_addr;
  logic [DATA_WIDTH-1:0]   beat_data;
`ifdef REG_DUMP_CSUM_EN
  logic [DATA_WIDTH-1:0]   csum_q, csum_d;
`endif

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    hi_d      = hi_q;
    done_d    = 1'b0;
    load_req  = 1'b0;
    beat_addr = '0;
    beat_data = '0;
    beat_last = 1'b0;
    beat_csum = 1'b0;
`ifdef REG_DUMP_CSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d   = lo_addr;
          hi_d    = hi_addr;
          state_d = S_RUN;
`ifdef REG_DUMP_CSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_RUN: begin
        load_req  = 1'b1;
        beat_addr = cur_q;
        beat_data = rdata;
`ifndef REG_DUMP_CSUM_EN
        beat_last = (cur_q == hi_q);
`endif
        if (load_en) begin
`ifdef REG_DUMP_CSUM_EN
          csum_d = csum_q + rdata;
`endif
          // Counter wraps naturally at 2**ADDR_WIDTH, which covers lo > hi.
          if (cur_q == hi_q) begin
`ifdef REG_DUMP_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DRAIN;
`endif
          end else begin
            cur_d = cur_q + ADDR_WIDTH'(1);
          end
        end
      end
`ifdef REG_DUMP_CSUM_EN
      S_CSUM: begin
        load_req  = 1'b1;
        beat_addr = ADDR_WIDTH'(CSUM_ADDR);
        beat_data = csum_q;
        beat_last = 1'b1;
        beat_csum = 1'b1;
        if (load_en) state_d = S_DRAIN;
      end
`endif
      S_DRAIN: begin
        if (out_valid && out_ready) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      hi_q    <= '0;
      done_q  <= 1'b0;
`ifdef REG_DUMP_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
`ifdef REG_DUMP_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign raddr = (state_q == S_RUN) ? cur_q : '0;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;

  reg_dump_obuf #(
    .DW(DATA_WIDTH),
    .AW(ADDR_WIDTH)
  ) u_obuf (
    .clk      (clk),
    .rst      (rst),
    .load_req (load_req),
    .in_addr  (beat_addr),
    .in_data  (beat_data),
    .in_last  (beat_last),
    .in_csum  (beat_csum),
    .load_en  (load_en),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_addr (out_addr),
    .out_data (out_data),
    .out_last (out_last),
    .out_csum (out_csum)
  );
endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: range walks, wrap, single register, backpressure, reset abort.
module tb_reg_dump;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef REG_DUMP_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b1;
  logic [AW-1:0] lo_addr = '0;
  logic [AW-1:0] hi_addr = '0;
  logic [AW-1:0] raddr, out_addr;
  logic [DW-1:0] rdata, out_data;
  logic          out_valid, out_last, out_csum, busy, done;
  logic [DW-1:0] rf [32];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;
  assign rdata = rf[raddr];

  reg_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .lo_addr(lo_addr), .hi_addr(hi_addr),
    .raddr(raddr), .rdata(rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last), .out_csum(out_csum),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a dump and checks every accepted beat against the bench's own walk of rf.
  task automatic run_dump(input logic [AW-1:0] lo, input logic [AW-1:0] hi, input bit bp);
    int            n, total, beat, cyc;
    bit            got_done, stalled;
    logic [DW-1:0] sum;
    logic [AW-1:0] ea;
    logic [63:0]   held, cur, expv;
    n     = (hi >= lo) ? int'(hi) - int'(lo) + 1 : 32 - int'(lo) + int'(hi) + 1;
    total = n + CS;
    sum   = '0;
    for (int i = 0; i < n; i++) begin
      ea  = lo + AW'(i);
      sum = sum + rf[ea];
    end
    beat = 0; cyc = 0; got_done = 0; stalled = 0; held = '0;
    lo_addr = lo; hi_addr = hi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start", busy, 1);
    chk("raddr_first", raddr, lo);
    chk("valid_first", out_valid, 0);
    while (!got_done && cyc < 400) begin
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      // A stray start mid-dump must be ignored.
      if (cyc == 3 && total >= 3) begin
        start = 1'b1; lo_addr = lo ^ 5'h1f;
      end else begin
        start = 1'b0;
      end
      cur = 64'({out_addr, out_data, out_last, out_csum});
      if (done) begin
        got_done = 1;
        chk("beats_total", beat, total);
        chk("busy_done", busy, 0);
        chk("valid_done", out_valid, 0);
        if (!bp) chk("done_cycle", cyc, n + 1 + CS);
      end else if (out_valid) begin
        if (stalled) chk("hold", cur, held);
        if (out_ready) begin
          if (beat < n) begin
            ea   = lo + AW'(beat);
            expv = 64'({ea, rf[ea], (beat == n - 1) && (CS == 0), 1'b0});
          end else begin
            expv = 64'({AW'(0), sum, 1'b1, 1'b1});
          end
          if (beat >= total) chk("extra_beat", beat, total);
          else chk("beat", cur, expv);
          beat++;
          stalled = 0;
        end else begin
          held    = cur;
          stalled = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (!got_done) chk("done_timeout", got_done, 1);
    start = 1'b0; out_ready = 1'b1;
    chk("done_pulse", done, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = DW'(i * 3);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_csum", out_csum, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_raddr", raddr, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    run_dump(5'd0, 5'd31, 1'b0);
    run_dump(5'd30, 5'd1, 1'b0);
    rf[7] = 32'hDEADBEEF;
    run_dump(5'd7, 5'd7, 1'b0);
    run_dump(5'd4, 5'd6, 1'b1);
    rf[1] = 32'd5; rf[2] = 32'd10; rf[3] = 32'd20;
    run_dump(5'd1, 5'd3, 1'b0);

    // Reset while the second beat is on the output.
    lo_addr = 5'd0; hi_addr = 5'd31; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_beat2_addr", out_addr, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_raddr", raddr, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    run_dump(5'd2, 5'd5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_dump.md
# reg_dump

Debug read-out engine for the MIPS core's 32-entry register file. On a start pulse it walks a programmable address range through one of the register file's combinational read ports and streams each `{address, data}` pair out over a valid/ready handshake toward the debug/host link. It sits beside the core's decode stage and borrows the second read port while `busy` is high; the core stalls its register writes during that time.

## Interface
Parameters:
- `DATA_WIDTH`, 32: register data width.
- `ADDR_WIDTH`, 5: register address width; number of registers is `2**ADDR_WIDTH`.

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset, synchronous, active-low.
- `start`  input  1  request a dump; sampled only in IDLE.
- `lo_addr`  input  ADDR_WIDTH  first register address; latched on an accepted start.
- `hi_addr`  input  ADDR_WIDTH  last register address; latched on an accepted start.
- `raddr`  output  ADDR_WIDTH  drives the register file read port.
- `rdata`  input  DATA_WIDTH  combinational read data for `raddr`, same cycle.
- `out_valid`  output  1  beat present.
- `out_ready`  input  1  sink accepts the beat.
- `out_addr`  output  ADDR_WIDTH  register address of the beat.
- `out_data`  output  DATA_WIDTH  register value of the beat.
- `out_last`  output  1  final beat of the dump.
- `out_csum`  output  1  beat carries the checksum.
- `busy`  output  1  dump in progress; the core must not write the register file.
- `done`  output  1  one-cycle pulse after the final beat is accepted.

## Operation
- States: IDLE, RUN, CSUM, DRAIN.
- IDLE: when `start`=1, latch `lo_addr`/`hi_addr`, set `cur`=lo, clear the checksum, and go to RUN. `busy`=1 from the next cycle.
- RUN: `raddr`=`cur`. The output register loads when `!out_valid || out_ready`. On load:
  - `out_addr`=`cur`, `out_data`=`rdata`, `out_valid`=1.
  - Checksum += `rdata`.
  - If `cur`==hi, go to CSUM (macro on) or DRAIN (macro off). Otherwise `cur` = (`cur`+1) mod 2**ADDR_WIDTH.
- Range wrap: if lo>hi, the walk covers lo..2**ADDR_WIDTH-1 and then 0..hi. If lo==hi, exactly one data beat is sent.
- CSUM: when the output register is free, load `out_data`=checksum, `out_addr`=0, `out_csum`=1, `out_last`=1. Then go to DRAIN.
- DRAIN: wait for `out_valid && out_ready`, then pulse `done`, drop `busy`, and return to IDLE.
- `out_last` is set on the final beat: the last data beat when the macro is off, the checksum beat when it is on.
- A beat's outputs are held stable while `out_valid && !out_ready`.
- `start` outside IDLE is ignored.
- Register 0 is passed through as read; it gets no special handling.
- Reset values: `out_valid`=0, `out_addr`=0, `out_data`=0, `out_last`=0, `out_csum`=0, `busy`=0, `done`=0, `raddr`=0, state IDLE.
- Reset in the middle of a dump aborts it immediately. No `done` pulse is issued and no beat remains.

## Timing
- Let edge E be the edge that samples `start`. `raddr`=lo during the cycle after E. The first beat is visible after edge E+1.
- With `out_ready` held at 1, throughput is one beat per cycle. An N-register dump with the macro off gives `done`=1 in the cycle after edge E+N+1.
- With the macro on, there is one extra cycle for the checksum beat.
- Backpressure inserts no bubbles beyond the stall cycles themselves.
- `done` is high for exactly one cycle. `busy` is 0 in that same cycle.

## Configuration
- `REG_DUMP_CSUM_EN` defined: the CSUM state exists. A trailing checksum beat (32-bit sum mod 2**DATA_WIDTH of all data beats) is sent, and `out_last` moves to that beat.
- `REG_DUMP_CSUM_EN` not defined: the CSUM state and the checksum accumulator are removed. `out_csum` is tied to 0.

## Structure
- Package `reg_dump_pkg`:
  - width constants `DATA_WIDTH`, `ADDR_WIDTH`, `NUM_REGS`;
  - the state encoding (IDLE, RUN, CSUM, DRAIN);
  - the checksum-beat address constant (0).
- Sub-module `reg_dump_obuf`: the single output register stage. It holds valid/addr/data/last/csum, generates the load enable (`!out_valid || out_ready`), and provides the handshake hold. The top level contains the FSM, the address counter and the checksum.

## Test plan
- Full range, lo=0, hi=31, `out_ready`=1, regs preloaded with `rf[i]=i*3` -> 32 beats with addr 0..31 and data 0,3,..,93; `out_last` only on addr 31 (macro off); `done` in the cycle after edge E+33.
- Wrap, lo=30, hi=1 -> beats with addr 30,31,0,1 in that order; `out_last` on addr 1.
- Single register, lo=hi=7, `rf[7]`=0xDEADBEEF -> one beat with addr 7, data 0xDEADBEEF, `out_last`=1.
- Backpressure: `out_ready` toggles 1,0,0,1 on the lo=4, hi=6 dump -> each beat is held stable while stalled; there are no duplicates or drops; the order is 4,5,6.
- Checksum (macro on): lo=1, hi=3 with values 5,10,20 -> 3 data beats, then a checksum beat with `out_csum`=1, `out_last`=1, data 35, addr 0.
- Reset during a dump: `rst`=0 for one cycle after the 2nd beat -> next cycle `out_valid`=0, `busy`=0, no `done`; a new `start` then dumps normally.
